// File: rtl/univ_shift_reg.sv
`default_nettype none
// ==== univ_shift_reg : universal shift/rotate register with autonomous burst engine ====
// ==== rev 1.0 ===========================================================================
module univ_shift_reg #(
   parameter int unsigned            WIDTH     = 8,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0,
   parameter int unsigned            CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] Q,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] c_hold = 3'b000;
   localparam logic [2:0] c_load = 3'b001;
   localparam logic [2:0] c_shl  = 3'b010;
   localparam logic [2:0] c_shr  = 3'b011;
   localparam logic [2:0] c_rotl = 3'b100;
   localparam logic [2:0] c_rotr = 3'b101;
   localparam logic [2:0] c_ashr = 3'b110;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] w_shl, w_shr, w_rotl, w_rotr, w_ashr, w_op_res;
   logic [2:0]       w_sel_op;
   logic             w_is_shift;

   // A one-bit register has no neighbours: rotates and ashr degenerate to hold.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_shl  = sin_l;
         assign w_shr  = sin_r;
         assign w_rotl = q_q;
         assign w_rotr = q_q;
         assign w_ashr = q_q;
      end else begin : g_wn
         assign w_shl  = {q_q[WIDTH-2:0], sin_l};
         assign w_shr  = {sin_r, q_q[WIDTH-1:1]};
         assign w_rotl = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
         assign w_rotr = {q_q[0], q_q[WIDTH-1:1]};
         assign w_ashr = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      end
   endgenerate

   assign w_sel_op   = (state_q == BURST) ? op_q : mode;
   assign w_is_shift = (mode == c_shl) || (mode == c_shr) || (mode == c_rotl) ||
                       (mode == c_rotr) || (mode == c_ashr);

   always_comb begin
      w_op_res = q_q;
      case (w_sel_op)
         c_load:  w_op_res = D;
         c_shl:   w_op_res = w_shl;
         c_shr:   w_op_res = w_shr;
         c_rotl:  w_op_res = w_rotl;
         c_rotr:  w_op_res = w_rotr;
         c_ashr:  w_op_res = w_ashr;
         default: w_op_res = q_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      done_d  = 1'b0;
      if (en) begin
         if (state_q == IDLE) begin
            // An accepted burst request pre-empts the mode op on this edge.
            if (burst_start && w_is_shift && (burst_len != '0)) begin
               op_d    = mode;
               cnt_d   = burst_len;
               state_d = BURST;
            end else begin
               q_d = w_op_res;
            end
         end else begin
            q_d   = w_op_res;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         op_q    <= c_hold;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         done_q  <= done_d;
      end
   end

   assign Q        = q_q;
   assign sout_msb = q_q[WIDTH-1];
   assign sout_lsb = q_q[0];
   assign busy     = (state_q == BURST);
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ==== tb_univ_shift_reg : vector table plus hand-built burst sequences, scoreboard checked ====
// ==== rev 1.0 ==================================================================================
module tb_univ_shift_reg;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROTL = 3'b100;
   localparam logic [2:0] M_ROTR = 3'b101;
   localparam logic [2:0] M_ASHR = 3'b110;
   localparam logic [2:0] M_HLD7 = 3'b111;

   typedef struct {
      logic       rst;
      logic       en;
      logic [2:0] mode;
      logic [7:0] d;
      logic       sl;
      logic       sr;
      logic       bs;
      logic [3:0] blen;
      logic [7:0] exp_q;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, en, sin_l, sin_r, burst_start;
   logic [2:0] mode;
   logic [7:0] D, Q;
   logic [3:0] burst_len;
   logic       sout_msb, sout_lsb, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t exp_q_fifo[$];
   vec_t tbl[28];

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .D(D),
      .sin_l(sin_l), .sin_r(sin_r), .burst_start(burst_start), .burst_len(burst_len),
      .Q(Q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic e, logic [2:0] m, logic [7:0] d,
                               logic sl, logic sr, logic bs, logic [3:0] bl,
                               logic [7:0] eq, logic eb, logic ed);
      vec_t v;
      v.rst = rst; v.en = e; v.mode = m; v.d = d; v.sl = sl; v.sr = sr;
      v.bs = bs; v.blen = bl; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
      return v;
   endfunction

   task automatic run(input vec_t v, input string name);
      vec_t e;
      reset = v.rst; en = v.en; mode = v.mode; D = v.d;
      sin_l = v.sl; sin_r = v.sr; burst_start = v.bs; burst_len = v.blen;
      exp_q_fifo.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q_fifo.pop_front();
      n_tests++;
      if (Q !== e.exp_q || busy !== e.exp_busy || done !== e.exp_done ||
          sout_msb !== e.exp_q[7] || sout_lsb !== e.exp_q[0]) begin
         n_fail++;
         $display("FAIL %s: got Q=%h busy=%b done=%b msb=%b lsb=%b, want Q=%h busy=%b done=%b",
                  name, Q, busy, done, sout_msb, sout_lsb, e.exp_q, e.exp_busy, e.exp_done);
      end
   endtask

   initial begin
      tbl[0]  = mk(1, 1, M_LOAD, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 0);
      tbl[1]  = mk(0, 1, M_LOAD, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0);
      tbl[2]  = mk(0, 1, M_LOAD, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0);
      tbl[3]  = mk(0, 1, M_ROTL, 8'h00, 0, 0, 0, 0, 8'h03, 0, 0);
      tbl[4]  = mk(0, 1, M_ROTL, 8'h00, 0, 0, 0, 0, 8'h06, 0, 0);
      tbl[5]  = mk(0, 1, M_ROTL, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 0);
      tbl[6]  = mk(0, 1, M_LOAD, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0);
      tbl[7]  = mk(0, 1, M_ROTR, 8'h00, 0, 0, 0, 0, 8'hC0, 0, 0);
      tbl[8]  = mk(0, 1, M_LOAD, 8'h80, 0, 0, 0, 0, 8'h80, 0, 0);
      tbl[9]  = mk(0, 1, M_ASHR, 8'h00, 0, 0, 0, 0, 8'hC0, 0, 0);
      tbl[10] = mk(0, 1, M_ASHR, 8'h00, 0, 0, 0, 0, 8'hE0, 0, 0);
      tbl[11] = mk(0, 1, M_LOAD, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
      tbl[12] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'h01, 0, 0);
      tbl[13] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'h03, 0, 0);
      tbl[14] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'h07, 0, 0);
      tbl[15] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'h0F, 0, 0);
      tbl[16] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'h1F, 0, 0);
      tbl[17] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'h3F, 0, 0);
      tbl[18] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'h7F, 0, 0);
      tbl[19] = mk(0, 1, M_SHL,  8'h00, 1, 0, 0, 0, 8'hFF, 0, 0);
      tbl[20] = mk(0, 1, M_SHR,  8'h00, 0, 0, 0, 0, 8'h7F, 0, 0);
      tbl[21] = mk(0, 1, M_HLD7, 8'h12, 1, 1, 0, 0, 8'h7F, 0, 0);
      tbl[22] = mk(0, 1, M_HOLD, 8'h34, 1, 1, 0, 0, 8'h7F, 0, 0);
      tbl[23] = mk(0, 0, M_LOAD, 8'h3C, 0, 0, 1, 3, 8'h7F, 0, 0);
      tbl[24] = mk(0, 1, M_LOAD, 8'h3C, 0, 0, 1, 0, 8'h3C, 0, 0);
      tbl[25] = mk(0, 1, M_LOAD, 8'h5A, 0, 0, 1, 4, 8'h5A, 0, 0);
      tbl[26] = mk(0, 1, M_SHR,  8'h00, 0, 1, 0, 0, 8'hAD, 0, 0);
      tbl[27] = mk(0, 1, M_ROTR, 8'h00, 0, 0, 0, 0, 8'hD6, 0, 0);

      for (int i = 0; i < 28; i++) run(tbl[i], $sformatf("vec%0d", i));

      // Burst of 3 shl; mode/D during the burst must be ignored.
      run(mk(0, 1, M_LOAD, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0), "b1_load");
      run(mk(0, 1, M_SHL,  8'h00, 0, 0, 1, 3, 8'h01, 1, 0), "b1_accept");
      run(mk(0, 1, M_LOAD, 8'hFF, 0, 0, 1, 7, 8'h02, 1, 0), "b1_s1");
      run(mk(0, 1, M_LOAD, 8'hFF, 0, 0, 0, 0, 8'h04, 1, 0), "b1_s2");
      run(mk(0, 1, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h08, 0, 1), "b1_done");
      run(mk(0, 1, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h08, 0, 0), "b1_after");

      // Same burst with a one-cycle stall, then a new burst accepted on the done cycle.
      run(mk(0, 1, M_LOAD, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0), "b2_load");
      run(mk(0, 1, M_SHL,  8'h00, 0, 0, 1, 3, 8'h01, 1, 0), "b2_accept");
      run(mk(0, 1, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h02, 1, 0), "b2_s1");
      run(mk(0, 0, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h02, 1, 0), "b2_stall");
      run(mk(0, 1, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h04, 1, 0), "b2_s2");
      run(mk(0, 1, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h08, 0, 1), "b2_done");
      run(mk(0, 1, M_ROTR, 8'h00, 0, 0, 1, 2, 8'h08, 1, 0), "b3_accept");
      run(mk(0, 1, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h04, 1, 0), "b3_s1");
      run(mk(0, 1, M_HOLD, 8'h00, 0, 0, 0, 0, 8'h02, 0, 1), "b3_done");

      // Burst of 5 with live sin_l=1, aborted by reset after 2 shifts.
      run(mk(0, 1, M_LOAD, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0), "b4_load");
      run(mk(0, 1, M_SHL,  8'h00, 1, 0, 1, 5, 8'h01, 1, 0), "b4_accept");
      run(mk(0, 1, M_HOLD, 8'h00, 1, 0, 0, 0, 8'h03, 1, 0), "b4_s1");
      run(mk(0, 1, M_HOLD, 8'h00, 1, 0, 0, 0, 8'h07, 1, 0), "b4_s2");
      run(mk(1, 1, M_HOLD, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0), "b4_reset");
      for (int i = 0; i < 4; i++)
         run(mk(0, 1, M_HOLD, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0), $sformatf("b4_quiet%0d", i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
